raster_to_block: RTL and testbench
==================================

// Module: raster_to_block
// PURPOSE
//   Converts a raster-scan pixel stream (one N-bit signed pixel per beat, row-major over an
//   IMG_W x IMG_H frame) into 8x8 blocks packed as one flat N*64-bit window per beat.
//   Sits directly upstream of dct2d and drives its data_in window.
//   Ping-pong strip buffer (2 banks x 8 rows x IMG_W) so one 8-row strip fills while the previous drains.
// PARAMETERS
//   N      10   pixel width, signed two's complement
//   IMG_W  128  frame width in pixels; multiple of 8
//   IMG_H  128  frame height in pixels; multiple of 8
// PORTS
//   clk        in   1                  single clock, all logic on rising edge
//   rst_n      in   1                  asynchronous active-low reset
//   in_valid   in   1                  in_pixel is valid this cycle
//   in_ready   out  1                  block can accept a pixel this cycle
//   in_pixel   in   N                  raster pixel, signed
//   out_valid  out  1                  out_data/out_bx/out_by/out_last valid
//   out_ready  in   1                  consumer accepts the block this cycle
//   out_data   out  N*64               8x8 block, element k=r*8+c at bits [k*N +: N]
//   out_bx     out  clog2(IMG_W/8)     block column index
//   out_by     out  clog2(IMG_H/8)     block row (strip) index
//   out_last   out  1                  high on final block of the frame
// BEHAVIOUR
//   Reset (async assert, sync deassert seen at next edge): out_valid=0, out_data=0, out_bx=0,
//     out_by=0, out_last=0, in_ready=1; x/y write counters=0; wr_bank=rd_bank=0; both banks empty.
//     Reset mid-strip or mid-drain discards all buffered pixels; no partial block is ever emitted.
//   Input transfer = in_valid & in_ready. Pixel written to bank[wr_bank][y%8][x]; x increments,
//     wraps IMG_W-1 -> 0 with y increment; y wraps IMG_H-1 -> 0 (next frame, no gap required).
//   Bank state per bank: EMPTY -> FILLING (first pixel) -> FULL (pixel x=IMG_W-1, y%8=7 accepted)
//     -> EMPTY (block bx=IMG_W/8-1 of that bank accepted downstream).
//   On FULL, wr_bank toggles. in_ready = (bank[wr_bank] != FULL); registered, so it deasserts the
//     cycle after the strip-completing pixel when the other bank is still draining.
//   Read side: output register loads when (!out_valid | out_ready) and bank[rd_bank] FULL:
//     out_data <= 64 pixels rows 0..7, cols bx*8..bx*8+7 of rd_bank; out_bx <= bx; out_by <= strip;
//     out_last <= (bx==IMG_W/8-1) & (strip==IMG_H/8-1). bx increments per load; after last block
//     rd_bank toggles, bank marked EMPTY in the same cycle the final block is accepted.
//   Latency: strip-completing pixel accepted at edge t -> out_valid=1 with bx=0 after edge t+1.
//   Throughput: one block per cycle while draining and out_ready=1.
//   out_valid/out_data/out_bx/out_by/out_last held stable while out_valid & !out_ready.
//   Simultaneous: bank release and other bank FULL in same cycle -> in_ready=1 next cycle, no
//     lost or duplicated pixel; in_valid while !in_ready -> pixel ignored, counters unchanged.
//   No arithmetic on pixel data; values pass bit-exact (sign preserved).
// TESTING
//   1 Reset then full 128x128 frame, pixel(y,x)=((y*8+x)&0x1FF)-256, out_ready=1 -> 256 blocks in
//     order (by,bx)=(0,0)..(15,15); block(0,1) element k=9 equals pixel(1,9)=-239; out_last only on (15,15).
//   2 Timing: last pixel of strip 0 (y=7,x=127) accepted at edge t -> out_valid=1, out_bx=0, out_by=0
//     after edge t+1; 16 consecutive blocks on cycles t+1..t+16.
//   3 Backpressure: out_ready=0 for 3000 cycles during stream -> in_ready drops after 2nd strip
//     completes (2048 pixels accepted), out_data stable; releasing out_ready resumes with no loss.
//   4 Random in_valid (50%) and out_ready (30%) over 2 frames -> scoreboard bit-exact vs golden
//     model, frame 2 starts at out_by=0, out_bx=0.
//   5 rst_n asserted mid-strip (y=3,x=40) and mid-drain (bx=5) -> outputs to reset values
//     immediately; restarted frame yields block(0,0) from new pixels only.
//   6 Extremes: pixels -512 and 511 alternating -> values preserved bit-exact in out_data.

Source files
------------

// File: rtl/raster_to_block.sv
// raster_to_block: turns a row-major raster pixel stream into 8x8 blocks.
// Two strip banks (8 rows x IMG_W each) alternate. One bank fills from the raster
// input while the other drains to the output one 64-pixel window per beat.
// Pixel values are stored and forwarded bit-exact.
//
// Handshake: both ports use valid/ready. A transfer happens on a rising edge where
// valid and ready are both high. A producer holding valid keeps its payload stable
// until the transfer. This block holds out_valid and every out_* payload bit
// unchanged while out_valid is high and out_ready is low. in_ready does not depend
// combinationally on in_valid.
module raster_to_block #(
   parameter int  N     = 10,
   parameter int  IMG_W = 128,
   parameter int  IMG_H = 128,
   localparam int BXW   = $clog2(IMG_W / 8),
   localparam int BYW   = $clog2(IMG_H / 8)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N-1:0]      in_pixel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N*64-1:0]   out_data,
   output logic [BXW-1:0]    out_bx,
   output logic [BYW-1:0]    out_by,
   output logic              out_last
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);

   localparam logic [XW-1:0]  X_LAST  = XW'(IMG_W - 1);
   localparam logic [YW-1:0]  Y_LAST  = YW'(IMG_H - 1);
   localparam logic [BXW-1:0] BX_LAST = BXW'(IMG_W / 8 - 1);
   localparam logic [BYW-1:0] BY_LAST = BYW'(IMG_H / 8 - 1);

   // Per-bank occupancy. FULL stays set until the last block of that bank has been
   // accepted downstream. The write side therefore never overwrites undrained pixels.
   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_state_t;

   logic [N-1:0]     mem [2][8][IMG_W];

   bank_state_t      bank_state [2];
   bank_state_t      bank_next  [2];

   logic [XW-1:0]    wr_x;
   logic [YW-1:0]    wr_y;
   logic             wr_bank;
   logic             wr_bank_next;

   logic             rd_bank;
   logic [BXW-1:0]   rd_bx;
   logic [BYW-1:0]   rd_strip;

   // When set, the block in the output register is the last one of bank out_rel_bank.
   logic             out_rel;
   logic             out_rel_bank;

   logic             in_fire;
   logic             out_fire;
   logic             strip_done;
   logic             load;
   logic             rel_fire;
   logic             last_blk;
   logic [N*64-1:0]  blk;

   assign in_fire      = in_valid & in_ready;
   assign out_fire     = out_valid & out_ready;
   assign strip_done   = in_fire & (wr_x == X_LAST) & (wr_y[2:0] == 3'd7);
   assign load         = (~out_valid | out_ready) & (bank_state[rd_bank] == BANK_FULL);
   assign rel_fire     = out_fire & out_rel;
   assign last_blk     = (rd_bx == BX_LAST);
   assign wr_bank_next = wr_bank ^ strip_done;

   // Next bank occupancy: the read side releases, and the write side starts or completes a strip.
   // The released bank is FULL, while an accepted pixel needs a non-FULL write bank, so the two never collide.
   always_comb begin
      bank_next = bank_state;
      if (rel_fire) begin
         bank_next[out_rel_bank] = BANK_EMPTY;
      end
      if (in_fire) begin
         if (strip_done) begin
            bank_next[wr_bank] = BANK_FULL;
         end else if (bank_state[wr_bank] == BANK_EMPTY) begin
            bank_next[wr_bank] = BANK_FILLING;
         end
      end
   end

   // Bank state machine, raster write counters, write bank select and registered in_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_state[0] <= BANK_EMPTY;
         bank_state[1] <= BANK_EMPTY;
         wr_bank       <= 1'b0;
         wr_x          <= '0;
         wr_y          <= '0;
         in_ready      <= 1'b1;
      end else begin
         bank_state <= bank_next;
         wr_bank    <= wr_bank_next;
         in_ready   <= (bank_next[wr_bank_next] != BANK_FULL);
         if (in_fire) begin
            if (wr_x == X_LAST) begin
               wr_x <= '0;
               wr_y <= (wr_y == Y_LAST) ? '0 : wr_y + 1'b1;
            end else begin
               wr_x <= wr_x + 1'b1;
            end
         end
      end
   end

   // Strip storage. It has no reset; bank occupancy decides what is valid.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         mem[wr_bank][wr_y[2:0]][wr_x] <= in_pixel;
      end
   end

   // Gather block rd_bx of the draining bank. Element k = r*8+c sits at bits [k*N +: N].
   always_comb begin
      blk = '0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            blk[(r*8+c)*N +: N] = mem[rd_bank][3'(r)][{rd_bx, 3'(c)}];
         end
      end
   end

   // Output register and read cursor. The cursor moves to the other bank once its
   // last block is loaded, so the next strip can follow without a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_bx       <= '0;
         out_by       <= '0;
         out_last     <= 1'b0;
         out_rel      <= 1'b0;
         out_rel_bank <= 1'b0;
         rd_bank      <= 1'b0;
         rd_bx        <= '0;
         rd_strip     <= '0;
      end else begin
         if (load) begin
            out_valid    <= 1'b1;
            out_data     <= blk;
            out_bx       <= rd_bx;
            out_by       <= rd_strip;
            out_last     <= last_blk & (rd_strip == BY_LAST);
            out_rel      <= last_blk;
            out_rel_bank <= rd_bank;
            if (last_blk) begin
               rd_bx    <= '0;
               rd_bank  <= ~rd_bank;
               rd_strip <= (rd_strip == BY_LAST) ? '0 : rd_strip + 1'b1;
            end else begin
               rd_bx <= rd_bx + 1'b1;
            end
         end else if (out_fire) begin
            out_valid <= 1'b0;
            out_rel   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_raster_to_block.sv
// Bench for raster_to_block. Driver tasks push raster pixels. A monitor on the
// falling edge builds the expected 8x8 blocks from accepted pixels and checks every
// accepted output block in order against that expected queue.
module tb_raster_to_block;

   localparam int N     = 10;
   localparam int IMG_W = 128;
   localparam int IMG_H = 128;
   localparam int BXW   = $clog2(IMG_W / 8);
   localparam int BYW   = $clog2(IMG_H / 8);
   localparam int DW    = N * 64;
   localparam int EW    = DW + BXW + BYW + 1;

   localparam logic [N-1:0] PIX_M239 = N'(-239);
   localparam logic [N-1:0] PIX_MIN  = N'(-512);
   localparam logic [N-1:0] PIX_MAX  = N'(511);

   // ---------------- clock / reset / DUT ----------------
   logic             clk       = 1'b0;
   logic             rst_n     = 1'b1;
   logic             in_valid  = 1'b0;
   logic [N-1:0]     in_pixel  = '0;
   logic             out_ready = 1'b1;
   logic             in_ready;
   logic             out_valid;
   logic [DW-1:0]    out_data;
   logic [BXW-1:0]   out_bx;
   logic [BYW-1:0]   out_by;
   logic             out_last;

   always #5 clk = ~clk;

   raster_to_block #(.N(N), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pixel  (in_pixel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_bx    (out_bx),
      .out_by    (out_by),
      .out_last  (out_last)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- bench state ----------------
   int             checks = 0;
   int             errors = 0;
   logic [EW-1:0]  exp_q[$];
   logic [N-1:0]   sm [8][IMG_W];
   int             mx = 0, my = 0;
   int             sx = 0, sy = 0;
   int             ready_mode = 0;

   bit             hold_prev = 0;
   logic [EW:0]    held_vec;
   int             blocks_seen = 0;
   int             last_cnt = 0;
   logic [DW-1:0]  last_data;
   bit             acc_arm = 0, pop_arm = 0, cap01_arm = 0, nxt_arm = 0;
   int             t_acc = -100, first_cyc = -1, b15_cyc = -1;
   logic [N-1:0]   blk01 = '0;
   logic [BXW-1:0] nxt_bx = '1;
   logic [BYW-1:0] nxt_by = '1;

   // out_ready driver: 0 = always ready, 1 = stalled, 2 = ready 30% of cycles
   always begin
      @(posedge clk);
      #2;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         default: out_ready = ($urandom_range(0, 99) < 30);
      endcase
   end

   function automatic logic [N-1:0] pix0(input int y, input int x);
      return N'(((y * 8 + x) & 511) - 256);
   endfunction

   function automatic int first_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
      for (int k = 0; k < 64; k++) begin
         if (a[k*N +: N] !== b[k*N +: N]) return k;
      end
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic chk_data(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      int k;
      k = first_diff(got, exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s elem %0d got %h exp %h", tag, k, got[k*N +: N], exp[k*N +: N]);
      end
   endtask

   // ---------------- scoreboard model ----------------
   task automatic model_accept(input logic [N-1:0] px);
      logic [DW-1:0] d;
      logic          lst;
      sm[my % 8][mx] = px;
      if (acc_arm && my == 7 && mx == IMG_W - 1) begin
         t_acc   = cyc;
         acc_arm = 0;
      end
      if (mx == IMG_W - 1 && my % 8 == 7) begin
         for (int bx = 0; bx < IMG_W / 8; bx++) begin
            for (int r = 0; r < 8; r++)
               for (int c = 0; c < 8; c++)
                  d[(r*8+c)*N +: N] = sm[r][bx*8+c];
            lst = (bx == IMG_W / 8 - 1) && (my / 8 == IMG_H / 8 - 1);
            exp_q.push_back({lst, BYW'(my / 8), BXW'(bx), d});
         end
      end
      if (mx == IMG_W - 1) begin
         mx = 0;
         my = (my == IMG_H - 1) ? 0 : my + 1;
      end else begin
         mx++;
      end
   endtask

   // Monitor: hold stability, in-order block comparison, model update from accepted pixels
   always @(negedge clk) begin
      logic [EW:0]   cur;
      logic [EW-1:0] exp;
      int            k;
      if (rst_n) begin
         cur = {out_valid, out_last, out_by, out_bx, out_data};
         if (hold_prev) begin
            checks++;
            assert (cur === held_vec) else begin
               errors++;
               $error("FAIL hold valid=%0b bx=%0d by=%0d exp valid=1 bx=%0d by=%0d",
                      out_valid, out_bx, out_by, held_vec[DW +: BXW], held_vec[DW+BXW +: BYW]);
            end
         end
         hold_prev = out_valid && !out_ready;
         held_vec  = cur;
         if (out_valid && out_ready) begin
            blocks_seen++;
            last_data = out_data;
            if (out_last) last_cnt++;
            if (nxt_arm) begin
               nxt_bx  = out_bx;
               nxt_by  = out_by;
               nxt_arm = 0;
            end
            if (out_last) nxt_arm = 1;
            if (pop_arm && out_by == 0 && out_bx == 0) first_cyc = cyc;
            if (pop_arm && out_by == 0 && out_bx == BXW'(IMG_W / 8 - 1)) begin
               b15_cyc = cyc;
               pop_arm = 0;
            end
            if (cap01_arm && out_by == 0 && out_bx == 1) begin
               blk01     = out_data[9*N +: N];
               cap01_arm = 0;
            end
            checks++;
            assert (exp_q.size() != 0) else begin
               errors++;
               $error("FAIL extra_block got by=%0d bx=%0d exp none", out_by, out_bx);
            end
            if (exp_q.size() != 0) begin
               exp = exp_q.pop_front();
               k = first_diff(out_data, exp[DW-1:0]);
               checks++;
               assert ({out_last, out_by, out_bx, out_data} === exp) else begin
                  errors++;
                  $error("FAIL block got by=%0d bx=%0d last=%0b e%0d=%h exp by=%0d bx=%0d last=%0b e%0d=%h",
                         out_by, out_bx, out_last, k, out_data[k*N +: N],
                         exp[DW+BXW +: BYW], exp[DW +: BXW], exp[EW-1], k, exp[k*N +: N]);
               end
            end
         end
         if (in_valid && in_ready) model_accept(in_pixel);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      exp_q.delete();
      mx = 0; my = 0; sx = 0; sy = 0;
      hold_prev = 0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_bx", 64'(out_bx), 64'(0));
      chk("rst_out_by", 64'(out_by), 64'(0));
      chk("rst_out_last", 64'(out_last), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk_data("rst_out_data", out_data, '0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic send_px(input logic [N-1:0] v);
      int  waitc;
      bit  done;
      waitc    = 0;
      done     = 0;
      in_valid = 1'b1;
      in_pixel = v;
      while (!done) begin
         @(negedge clk);
         if (in_ready) done = 1;
         @(posedge clk);
         #1;
         if (!done) begin
            waitc++;
            if (waitc >= 5000) begin
               chk("send_timeout", 64'(waitc), 64'(0));
               done = 1;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   // pat 0: ((y*8+x)&0x1FF)-256, pat 1: -512/511 alternating on x, else random
   task automatic send_stream(input int count, input int pat, input bit rnd);
      logic [N-1:0] v;
      for (int i = 0; i < count; i++) begin
         if (rnd) begin
            while ($urandom_range(0, 1) == 0) begin
               in_valid = 1'b0;
               in_pixel = N'($urandom);
               @(posedge clk);
               #1;
            end
         end
         case (pat)
            0:       v = pix0(sy, sx);
            1:       v = (sx % 2 == 0) ? PIX_MIN : PIX_MAX;
            default: v = N'($urandom_range(0, (1 << N) - 1));
         endcase
         send_px(v);
         if (sx == IMG_W - 1) begin
            sx = 0;
            sy = (sy == IMG_H - 1) ? 0 : sy + 1;
         end else begin
            sx++;
         end
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_left", 64'(exp_q.size()), 64'(0));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int            start;
      int            ready_seen;
      int            n;
      int            base;
      logic [DW-1:0] held;

      do_reset();

      // full frame at full rate, strip 0 timing
      acc_arm = 1; pop_arm = 1; cap01_arm = 1;
      ready_mode = 0;
      send_stream(IMG_W * IMG_H, 0, 0);
      wait_drain();
      chk("frame1_blocks", 64'(blocks_seen), 64'(256));
      chk("frame1_last_count", 64'(last_cnt), 64'(1));
      chk("blk01_k9", 64'(blk01), 64'(PIX_M239));
      chk("strip0_first_cycle", 64'(first_cyc), 64'(t_acc + 2));
      chk("strip0_bx15_cycle", 64'(b15_cyc), 64'(t_acc + 17));

      // backpressure: two strips fill, then input stalls
      ready_mode = 1;
      @(posedge clk);
      #1;
      start = cyc;
      send_stream(2 * 8 * IMG_W, 0, 0);
      in_valid = 1'b1;
      in_pixel = pix0(sy, sx);
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_out_valid", 64'(out_valid), 64'(1));
      chk("stall_out_bx", 64'(out_bx), 64'(0));
      held = out_data;
      ready_seen = 0;
      while (cyc - start < 3000) begin
         @(negedge clk);
         if (in_ready) ready_seen++;
      end
      chk("stall_ready_low", 64'(ready_seen), 64'(0));
      chk_data("stall_data_stable", out_data, held);
      @(posedge clk);
      #1;

      // random traffic over the rest of frame 2 and into frame 3
      ready_mode = 2;
      send_stream(IMG_W * IMG_H - 2 * 8 * IMG_W, 2, 1);
      nxt_bx = '1;
      nxt_by = '1;
      send_stream(4 * 8 * IMG_W, 2, 1);
      wait_drain();
      chk("frame3_first_by", 64'(nxt_by), 64'(0));
      chk("frame3_first_bx", 64'(nxt_bx), 64'(0));

      // reset mid-strip at y=3, x=40
      ready_mode = 0;
      do_reset();
      send_stream(3 * IMG_W + 40, 0, 0);
      do_reset();

      // reset mid-drain at bx=5
      send_stream(8 * IMG_W, 0, 0);
      n = 0;
      while (!(out_valid && out_bx == 5) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_reached_bx5", 64'(out_bx), 64'(5));
      do_reset();
      base = blocks_seen;
      send_stream(8 * IMG_W, 2, 0);
      wait_drain();
      chk("restart_blocks", 64'(blocks_seen - base), 64'(16));

      // extremes -512 / 511
      send_stream(8 * IMG_W, 1, 0);
      wait_drain();
      chk("ext_k0", 64'(last_data[0 +: N]), 64'(PIX_MIN));
      chk("ext_k1", 64'(last_data[N +: N]), 64'(PIX_MAX));
      chk("ext_k63", 64'(last_data[63*N +: N]), 64'(PIX_MAX));
      chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
